// File: rtl/dds_cmd_pkg.sv
// Shared types and defaults for the DDS command frame parser.
package dds_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CHK   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
    localparam int unsigned DATA_BYTES_DEF = 4;
    localparam int unsigned IDX_W          = $clog2(DATA_BYTES_DEF + 1);

    function automatic int unsigned idxWidth(input int unsigned nBytes);
        return $clog2(nBytes + 1);
    endfunction

endpackage

// File: rtl/dds_cmd_errstat.sv
// Error pulse registers and saturating error counter for the DDS command parser.
module dds_cmd_errstat #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chkErr,
    input  logic             frmErr,
    input  logic             ovrErr,
    output logic             err_chk,
    output logic             err_frame,
    output logic             err_ovr,
    output logic [CNT_W-1:0] err_cnt
);

    logic anyErr;

    assign anyErr = chkErr | frmErr | ovrErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chk   <= 1'b0;
            err_frame <= 1'b0;
            err_ovr   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_chk   <= chkErr;
            err_frame <= frmErr;
            err_ovr   <= ovrErr;
            // Simultaneous causes count once; stick at all-ones.
            if (anyErr && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dds_cmd_parser.sv
// Frame parser between the RS-232 byte receiver and the DDS register writer:
// SYNC, ADDR, data bytes (MSB first), XOR checksum -> one valid/ready write.
module dds_cmd_parser
    import dds_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int unsigned DATA_BYTES = DATA_BYTES_DEF,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_ready,
    input  logic                    rx_endofpacket,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    err_frame,
    output logic                    err_chk,
    output logic                    err_ovr,
    output logic [15:0]             frame_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    localparam int unsigned      DW       = 8 * DATA_BYTES;
    localparam int unsigned      IdxW     = idxWidth(DATA_BYTES);
    localparam logic [IdxW-1:0]  LAST_IDX = IdxW'(DATA_BYTES - 1);

    state_t            state, nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [DW-1:0]     shiftReg;
    logic [7:0]        xorReg;
    logic [IdxW-1:0]   idx;

    logic loadAddr, shiftEn, loadWr, wrDone;
    logic chkErr, frmErr, ovrErr;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nextState;
    end

    // End of packet outranks a byte strobe while a frame is in progress.
    always_comb begin
        nextState = state;
        loadAddr  = 1'b0;
        shiftEn   = 1'b0;
        loadWr    = 1'b0;
        wrDone    = 1'b0;
        chkErr    = 1'b0;
        frmErr    = 1'b0;
        ovrErr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_data_ready && (rx_data == SYNC_BYTE))
                    nextState = S_ADDR;
            end
            S_ADDR: begin
                if (rx_endofpacket) begin
                    frmErr    = 1'b1;
                    nextState = S_IDLE;
                end else if (rx_data_ready) begin
                    loadAddr  = 1'b1;
                    nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_endofpacket) begin
                    frmErr    = 1'b1;
                    nextState = S_IDLE;
                end else if (rx_data_ready) begin
                    shiftEn = 1'b1;
                    if (idx == LAST_IDX)
                        nextState = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_endofpacket) begin
                    frmErr    = 1'b1;
                    nextState = S_IDLE;
                end else if (rx_data_ready) begin
                    if (rx_data == xorReg) begin
                        loadWr    = 1'b1;
                        nextState = S_WRITE;
                    end else begin
                        chkErr    = 1'b1;
                        nextState = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                ovrErr = rx_data_ready;
                if (wr_valid && wr_ready) begin
                    wrDone    = 1'b1;
                    nextState = S_IDLE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrReg   <= '0;
            shiftReg  <= '0;
            xorReg    <= '0;
            idx       <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_cnt <= '0;
        end else begin
            if (loadAddr) begin
                addrReg <= rx_data[ADDR_W-1:0];
                xorReg  <= rx_data;
                idx     <= '0;
            end
            if (shiftEn) begin
                shiftReg <= DW'({shiftReg, rx_data});
                xorReg   <= xorReg ^ rx_data;
                idx      <= idx + 1'b1;
            end
            if (loadWr) begin
                wr_addr  <= addrReg;
                wr_data  <= shiftReg;
                wr_valid <= 1'b1;
            end
            if (wrDone) begin
                wr_valid  <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    dds_cmd_errstat #(
        .CNT_W(CNT_W)
    ) u_errstat (
        .clk      (clk),
        .rst_n    (rst_n),
        .chkErr   (chkErr),
        .frmErr   (frmErr),
        .ovrErr   (ovrErr),
        .err_chk  (err_chk),
        .err_frame(err_frame),
        .err_ovr  (err_ovr),
        .err_cnt  (err_cnt)
    );

endmodule
